// File: rtl/ecg_stream_src.sv
// Paced playback of stored ECG frames onto a valid/ready stream.
// Define ECG_STREAM_SRC_LOOP_EN to enable continuous looping via loop_en.
module ecg_stream_src #(
    parameter int CHANNELS   = 2,
    parameter int DATA_WIDTH = 11,
    parameter int DEPTH      = 21600,
    parameter int CTR_WIDTH  = 24,
    parameter int RATE_WIDTH = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           nrst,
    input  logic                           wr_en,
    input  logic [AW-1:0]                  wr_addr,
    input  logic [CHANNELS*DATA_WIDTH-1:0] wr_data,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           loop_en,
    input  logic [AW:0]                    length,
    input  logic [RATE_WIDTH-1:0]          rate_div,
    output logic [CHANNELS*DATA_WIDTH-1:0] m_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [CTR_WIDTH-1:0]           counter,
    output logic                           busy,
    output logic                           done
);
    localparam int FW = CHANNELS * DATA_WIDTH;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, PACE, SEND, DONE} state_t;

    logic [FW-1:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [AW:0]           len_q, len_d;
    logic [RATE_WIDTH-1:0] rate_q, rate_d;
    logic [RATE_WIDTH-1:0] pace_q, pace_d;
    logic [CTR_WIDTH-1:0]  counter_q, counter_d;
    logic [FW-1:0]         data_q;
    logic                  rd_en;
    logic                  wr_ok;
    logic                  last;

`ifdef ECG_STREAM_SRC_LOOP_EN
    logic loop_q, loop_d;
`else
    logic unused_loop_en;
    assign unused_loop_en = loop_en;
`endif

    assign wr_ok = wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < DEPTH_L);
    assign last  = ({1'b0, addr_q} == (len_q - (AW+1)'(1)));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        rate_d    = rate_q;
        pace_d    = pace_q;
        counter_d = counter_q;
        rd_en     = 1'b0;
`ifdef ECG_STREAM_SRC_LOOP_EN
        loop_d    = loop_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && (length != '0)) begin
                    len_d     = (length > DEPTH_L) ? DEPTH_L : length;
                    rate_d    = rate_div;
                    addr_d    = '0;
                    pace_d    = '0;
                    counter_d = '0;
`ifdef ECG_STREAM_SRC_LOOP_EN
                    loop_d    = loop_en;
`endif
                    state_d   = PACE;
                end
            end
            PACE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (pace_q != '0) begin
                    pace_d = pace_q - RATE_WIDTH'(1);
                end else begin
                    rd_en   = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                // stop takes priority, so a coincident handshake is not counted
                if (stop) begin
                    state_d = IDLE;
                end else if (m_ready) begin
                    counter_d = counter_q + CTR_WIDTH'(1);
                    pace_d    = rate_q;
                    if (!last) begin
                        addr_d  = addr_q + AW'(1);
                        state_d = PACE;
                    end
`ifdef ECG_STREAM_SRC_LOOP_EN
                    else if (loop_q) begin
                        addr_d  = '0;
                        state_d = PACE;
                    end
`endif
                    else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            rate_q    <= '0;
            pace_q    <= '0;
            counter_q <= '0;
            data_q    <= '0;
`ifdef ECG_STREAM_SRC_LOOP_EN
            loop_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            rate_q    <= rate_d;
            pace_q    <= pace_d;
            counter_q <= counter_d;
`ifdef ECG_STREAM_SRC_LOOP_EN
            loop_q    <= loop_d;
`endif
            if (rd_en) begin
                data_q <= mem[addr_q];
            end
        end
    end

    // Frame store has no reset so contents survive nrst
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign m_data  = data_q;
    assign m_valid = (state_q == SEND);
    assign busy    = (state_q == PACE) || (state_q == SEND);
    assign done    = (state_q == DONE);
    assign counter = counter_q;

endmodule

// File: doc/ecg_stream_src.md
ECG_STREAM_SRC -- requirements
Module: ecg_stream_src

Interface
REQ-001 Parameters SHALL be: CHANNELS, 2, ECG leads per frame; DATA_WIDTH, 11, bits per sample; DEPTH, 21600, frames stored; CTR_WIDTH, 24, emitted-frame counter width; RATE_WIDTH, 16, pacing divider width; AW, $clog2(DEPTH), address width.
REQ-002 Ports SHALL be: clk  in  1  rising-edge clock.
REQ-003 nrst  in  1  reset, asynchronous, active-high.
REQ-004 wr_en  in  1  frame-memory write strobe; wr_addr  in  AW  write address; wr_data  in  CHANNELS*DATA_WIDTH  frame, channel 0 in LSBs.
REQ-005 start  in  1  begin playback; stop  in  1  abort playback; loop_en  in  1  restart at frame 0 after last frame.
REQ-006 length  in  AW+1  frames to play; rate_div  in  RATE_WIDTH  extra idle cycles between frames.
REQ-007 m_data  out  CHANNELS*DATA_WIDTH  frame; m_valid  out  1; m_ready  in  1  stream handshake.
REQ-008 counter  out  CTR_WIDTH  frames accepted since start; busy  out  1  playback active; done  out  1  one-cycle end pulse.

Function
REQ-009 FSM states SHALL be IDLE, PACE, SEND, DONE.
REQ-010 Writes SHALL occur only in IDLE with wr_addr < DEPTH; otherwise ignored.
REQ-011 IDLE, start=1, length!=0: SHALL latch len=min(length,DEPTH) and rate_div, clear addr, pace count and counter, enter PACE.
REQ-012 start with length=0, or start outside IDLE, SHALL be ignored.
REQ-013 PACE: pace count nonzero SHALL decrement; at zero SHALL issue synchronous memory read of addr and enter SEND.
REQ-014 SEND: m_valid=1, m_data = mem[addr], both held stable until m_ready=1.
REQ-015 Handshake (m_valid&m_ready) SHALL increment counter (wrapping modulo 2^CTR_WIDTH) and reload pace count with latched rate_div.
REQ-016 After handshake, addr<len-1: addr+1, PACE; addr=len-1, loop active: addr=0, PACE; else DONE.
REQ-017 With m_ready held high, frame spacing SHALL be rate_div+2 cycles handshake-to-handshake.
REQ-018 DONE SHALL assert done for exactly one cycle, then IDLE.
REQ-019 busy SHALL be 1 in PACE and SEND, 0 in IDLE and DONE.
REQ-020 stop=1 in PACE or SEND SHALL enter IDLE next cycle, drop m_valid, hold counter, no done pulse; stop wins over simultaneous start or handshake.
REQ-021 m_data SHALL hold its last value when m_valid=0.

Reset
REQ-022 nrst=1 SHALL asynchronously force IDLE, m_valid=0, m_data=0, counter=0, busy=0, done=0, addr=0, pace count=0.
REQ-023 Frame memory SHALL not be reset; contents persist across reset.
REQ-024 Reset mid-playback SHALL abandon playback without a done pulse.

Configuration
REQ-025 Macro ECG_STREAM_SRC_LOOP_EN defined: loop_en SHALL be sampled at start and govern REQ-016 wrap.
REQ-026 Macro undefined: loop_en SHALL be ignored, loop logic absent, playback always ends in DONE after len frames.

Verification
REQ-027 Load frames 0..3 with ch0=k, ch1=100+k; length=4, rate_div=0, m_ready=1, start -> 4 frames (0,100)..(3,103) 2 cycles apart, counter=4, one done pulse, busy falls.
REQ-028 length=3, rate_div=5, m_ready=1 -> handshakes 7 cycles apart, counter 1,2,3.
REQ-029 m_ready low 10 cycles during SEND -> m_valid and m_data stable 10 cycles, counter unchanged until ready.
REQ-030 Macro defined, loop_en=1, length=2 -> frames 0,1,0,1,... no done; stop -> m_valid=0 next cycle, IDLE, counter frozen.
REQ-031 nrst pulse mid-playback -> all outputs 0 immediately; restart replays stored frames unchanged.
REQ-032 length=0 start, start while busy, write while busy, wr_addr=DEPTH -> all ignored, memory and state unchanged.
